// File: rtl/bg_tile_fetcher_if.sv
// Background tile fetcher bus: request handshake, VRAM read port, tile output handshake.
interface bg_tile_fetcher_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] nametable_ptr;
  logic [2:0]  pattern_table_offset;
  logic [7:0]  ppu_ctrl1;
  logic [15:0] vram_addr;
  logic        vram_rd_req;
  logic        vram_rd_ack;
  logic [7:0]  vram_rd_data;
  logic        tile_valid;
  logic        tile_ready;
  logic [7:0]  tile_pattern_lo;
  logic [7:0]  tile_pattern_hi;
  logic [1:0]  tile_palette;

  modport master (
    input  req_valid, nametable_ptr, pattern_table_offset, ppu_ctrl1,
    input  vram_rd_ack, vram_rd_data, tile_ready,
    output req_ready, vram_addr, vram_rd_req,
    output tile_valid, tile_pattern_lo, tile_pattern_hi, tile_palette
  );

  modport slave (
    output req_valid, nametable_ptr, pattern_table_offset, ppu_ctrl1,
    output vram_rd_ack, vram_rd_data, tile_ready,
    input  req_ready, vram_addr, vram_rd_req,
    input  tile_valid, tile_pattern_lo, tile_pattern_hi, tile_palette
  );
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: for one accepted request, reads nametable, attribute,
// and both pattern planes from VRAM, then presents the tile on a valid/ready output.
module bg_tile_fetcher (
  input  logic           clk,
  input  logic           rst,
  bg_tile_fetcher_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_NT,
    FETCH_AT,
    FETCH_PLO,
    FETCH_PHI,
    WAIT_OUT
  } state_t;

  state_t      state, next_state;

  logic [15:0] ptr_q;
  logic [2:0]  fine_q;
  logic        ctrl4_q;
  logic [7:0]  nt_q;
  logic [7:0]  at_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;

  logic        load_out;
  logic [7:0]  out_hi;
  logic [1:0]  pal_sel;
  logic        accept;

  logic        unused_ctrl_bits;
  assign unused_ctrl_bits = ^{bus.ppu_ctrl1[7:5], bus.ppu_ctrl1[3:0]};

  assign accept = bus.req_valid && bus.req_ready;

  // Plane-1 byte comes straight off the bus on a direct load, from the holding latch when parked
  assign out_hi = (state == FETCH_PHI) ? bus.vram_rd_data : hi_q;

  // Quadrant select within the attribute byte: {coarse_y[1], coarse_x[1]}
  always_comb begin
    unique case ({ptr_q[6], ptr_q[1]})
      2'b00:   pal_sel = at_q[1:0];
      2'b01:   pal_sel = at_q[3:2];
      2'b10:   pal_sel = at_q[5:4];
      default: pal_sel = at_q[7:6];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, VRAM request/address and output-load decode
  always_comb begin
    next_state      = state;
    bus.req_ready   = 1'b0;
    bus.vram_rd_req = 1'b0;
    bus.vram_addr   = '0;
    load_out        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = FETCH_NT;
      end
      FETCH_NT: begin
        bus.vram_rd_req = 1'b1;
        bus.vram_addr   = ptr_q;
        if (bus.vram_rd_ack) next_state = FETCH_AT;
      end
      FETCH_AT: begin
        bus.vram_rd_req = 1'b1;
        bus.vram_addr   = 16'h23C0 | (ptr_q & 16'h0C00) |
                          ((ptr_q >> 4) & 16'h0038) | ((ptr_q >> 2) & 16'h0007);
        if (bus.vram_rd_ack) next_state = FETCH_PLO;
      end
      FETCH_PLO: begin
        bus.vram_rd_req = 1'b1;
        bus.vram_addr   = {3'b000, ctrl4_q, nt_q, 1'b0, fine_q};
        if (bus.vram_rd_ack) next_state = FETCH_PHI;
      end
      FETCH_PHI: begin
        bus.vram_rd_req = 1'b1;
        bus.vram_addr   = {3'b000, ctrl4_q, nt_q, 1'b1, fine_q};
        if (bus.vram_rd_ack) begin
          if (!bus.tile_valid || bus.tile_ready) begin
            load_out   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (bus.tile_ready) begin
          load_out   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latches and per-read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      fine_q  <= '0;
      ctrl4_q <= 1'b0;
      nt_q    <= '0;
      at_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (accept) begin
        ptr_q   <= bus.nametable_ptr;
        fine_q  <= bus.pattern_table_offset;
        ctrl4_q <= bus.ppu_ctrl1[4];
      end
      if (bus.vram_rd_ack) begin
        unique case (state)
          FETCH_NT:  nt_q <= bus.vram_rd_data;
          FETCH_AT:  at_q <= bus.vram_rd_data;
          FETCH_PLO: lo_q <= bus.vram_rd_data;
          FETCH_PHI: hi_q <= bus.vram_rd_data;
          default:   ;
        endcase
      end
    end
  end

  // Tile output registers and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tile_valid      <= 1'b0;
      bus.tile_pattern_lo <= '0;
      bus.tile_pattern_hi <= '0;
      bus.tile_palette    <= '0;
    end else begin
      if (load_out) begin
        bus.tile_valid      <= 1'b1;
        bus.tile_pattern_lo <= lo_q;
        bus.tile_pattern_hi <= out_hi;
        bus.tile_palette    <= pal_sel;
      end else if (bus.tile_ready) begin
        bus.tile_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: zero-wait, wait-state, backpressure, reset, spurious inputs.
module tb_bg_tile_fetcher;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bg_tile_fetcher_if bus ();

  bg_tile_fetcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serve one VRAM read: hold ack low for 'waits' cycles, checking req and address each cycle
  task automatic serve(input string tag, input logic [15:0] addr, input logic [7:0] data,
                       input int waits);
    bus.vram_rd_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_req_w"}, {15'd0, bus.vram_rd_req}, 16'd1);
      chk({tag, "_addr_w"}, bus.vram_addr, addr);
      step();
    end
    chk({tag, "_req"}, {15'd0, bus.vram_rd_req}, 16'd1);
    chk({tag, "_addr"}, bus.vram_addr, addr);
    bus.vram_rd_ack  = 1'b1;
    bus.vram_rd_data = data;
    step();
    bus.vram_rd_ack  = 1'b0;
    bus.vram_rd_data = 8'h00;
  endtask

  task automatic issue(input logic [15:0] ptr, input logic [2:0] off, input logic [7:0] ctrl);
    bus.nametable_ptr        = ptr;
    bus.pattern_table_offset = off;
    bus.ppu_ctrl1            = ctrl;
    bus.req_valid            = 1'b1;
    chk("req_ready_idle", {15'd0, bus.req_ready}, 16'd1);
    step();
    bus.req_valid            = 1'b0;
    // Scramble inputs after acceptance; the fetch must use the latched values
    bus.nametable_ptr        = 16'hFFFF;
    bus.pattern_table_offset = 3'd7;
    bus.ppu_ctrl1            = ~ctrl;
  endtask

  task automatic chk_tile(input string tag, input logic v, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [1:0] pal);
    chk({tag, "_valid"}, {15'd0, bus.tile_valid}, {15'd0, v});
    chk({tag, "_lo"}, {8'd0, bus.tile_pattern_lo}, {8'd0, lo});
    chk({tag, "_hi"}, {8'd0, bus.tile_pattern_hi}, {8'd0, hi});
    chk({tag, "_pal"}, {14'd0, bus.tile_palette}, {14'd0, pal});
  endtask

  initial begin
    rst                      = 1'b1;
    bus.req_valid            = 1'b0;
    bus.nametable_ptr        = 16'h0000;
    bus.pattern_table_offset = 3'd0;
    bus.ppu_ctrl1            = 8'h00;
    bus.vram_rd_ack          = 1'b0;
    bus.vram_rd_data         = 8'h00;
    bus.tile_ready           = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
    chk("rst_rd_req", {15'd0, bus.vram_rd_req}, 16'd0);
    chk_tile("rst_tile", 1'b0, 8'h00, 8'h00, 2'd0);
    rst = 1'b0;

    // Spurious ack in IDLE
    bus.vram_rd_ack  = 1'b1;
    bus.vram_rd_data = 8'h99;
    step();
    bus.vram_rd_ack  = 1'b0;
    chk("idle_ack_ready", {15'd0, bus.req_ready}, 16'd1);
    chk("idle_ack_rd_req", {15'd0, bus.vram_rd_req}, 16'd0);
    chk("idle_ack_valid", {15'd0, bus.tile_valid}, 16'd0);

    // Zero-wait fetch
    issue(16'h2863, 3'd5, 8'h10);
    chk("zw_busy_ready", {15'd0, bus.req_ready}, 16'd0);
    serve("zw_nt", 16'h2863, 8'h3A, 0);
    serve("zw_at", 16'h2BC0, 8'hE4, 0);
    serve("zw_plo", 16'h13A5, 8'h81, 0);
    chk("zw_not_yet_valid", {15'd0, bus.tile_valid}, 16'd0);
    serve("zw_phi", 16'h13AD, 8'h7E, 0);
    chk_tile("zw_tile", 1'b1, 8'h81, 8'h7E, 2'd3);
    chk("zw_back_idle", {15'd0, bus.req_ready}, 16'd1);
    chk("zw_rd_req_off", {15'd0, bus.vram_rd_req}, 16'd0);

    // Consume: valid clears with no simultaneous load
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready = 1'b0;
    chk("consume_valid", {15'd0, bus.tile_valid}, 16'd0);

    // Wait states: ack after 3 idle cycles per read
    issue(16'h2421, 3'd0, 8'h00);
    serve("ws_nt", 16'h2421, 8'h5B, 3);
    serve("ws_at", 16'h27C0, 8'h1E, 3);
    serve("ws_plo", 16'h05B0, 8'hC3, 3);
    serve("ws_phi", 16'h05B8, 8'h3C, 3);
    chk_tile("ws_tile", 1'b1, 8'hC3, 8'h3C, 2'd2);

    // Backpressure: second tile parks in WAIT_OUT while first stays stable
    issue(16'h2000, 3'd7, 8'hFF);
    serve("bp_nt", 16'h2000, 8'h01, 0);
    serve("bp_at", 16'h23C0, 8'h55, 0);
    serve("bp_plo", 16'h1017, 8'h11, 0);
    serve("bp_phi", 16'h101F, 8'h22, 0);
    chk("bp_wait_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("bp_wait_rd_req", {15'd0, bus.vram_rd_req}, 16'd0);
    chk_tile("bp_hold0", 1'b1, 8'hC3, 8'h3C, 2'd2);

    // Request while busy, plus a stray ack, must not disturb WAIT_OUT
    bus.nametable_ptr        = 16'h23C5;
    bus.pattern_table_offset = 3'd2;
    bus.ppu_ctrl1            = 8'h00;
    bus.req_valid            = 1'b1;
    bus.vram_rd_ack          = 1'b1;
    step();
    bus.vram_rd_ack          = 1'b0;
    step();
    chk("bp_busy_ready", {15'd0, bus.req_ready}, 16'd0);
    chk_tile("bp_hold1", 1'b1, 8'hC3, 8'h3C, 2'd2);

    // One tile_ready pulse: second tile shown next cycle
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready = 1'b0;
    chk_tile("bp_tile2", 1'b1, 8'h11, 8'h22, 2'd1);
    chk("bp_idle_ready", {15'd0, bus.req_ready}, 16'd1);

    // Held request accepted only now; ptr inside attribute area still fetched normally
    step();
    bus.req_valid     = 1'b0;
    bus.nametable_ptr = 16'hFFFF;
    serve("aa_nt", 16'h23C5, 8'hFF, 0);
    serve("aa_at", 16'h23F9, 8'h20, 0);
    serve("aa_plo", 16'h0FF2, 8'hA5, 0);
    chk_tile("aa_hold", 1'b1, 8'h11, 8'h22, 2'd1);
    // Simultaneous load and consume keeps valid with new data
    bus.tile_ready = 1'b1;
    serve("aa_phi", 16'h0FFA, 8'h5A, 0);
    bus.tile_ready = 1'b0;
    chk_tile("aa_tile", 1'b1, 8'hA5, 8'h5A, 2'd2);

    // Reset mid-fetch during FETCH_AT, overriding req_valid and tile_ready
    issue(16'h2863, 3'd5, 8'h10);
    serve("rm_nt", 16'h2863, 8'h3A, 0);
    chk("rm_at_addr", bus.vram_addr, 16'h2BC0);
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.tile_ready = 1'b1;
    step();
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.tile_ready = 1'b0;
    chk("rm_idle", {15'd0, bus.req_ready}, 16'd1);
    chk("rm_rd_req", {15'd0, bus.vram_rd_req}, 16'd0);
    chk_tile("rm_tile", 1'b0, 8'h00, 8'h00, 2'd0);

    // Stray ack after reset
    bus.vram_rd_ack  = 1'b1;
    bus.vram_rd_data = 8'hEE;
    step();
    bus.vram_rd_ack  = 1'b0;
    chk("stray_idle", {15'd0, bus.req_ready}, 16'd1);
    chk("stray_rd_req", {15'd0, bus.vram_rd_req}, 16'd0);
    chk("stray_valid", {15'd0, bus.tile_valid}, 16'd0);

    // Normal fetch after reset
    issue(16'h2421, 3'd3, 8'h10);
    serve("pr_nt", 16'h2421, 8'h80, 0);
    serve("pr_at", 16'h27C0, 8'h03, 0);
    serve("pr_plo", 16'h1803, 8'h0F, 0);
    serve("pr_phi", 16'h180B, 8'hF0, 0);
    chk_tile("pr_tile", 1'b1, 8'h0F, 8'hF0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_tile_fetcher.md
BG_TILE_FETCHER -- requirements
Module: bg_tile_fetcher

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  tile fetch request
- req_ready  output  1  fetcher can accept a request
- nametable_ptr  input  16  nametable byte address, 0x2000-0x2FFF, from pixel_to_nametable_ptr
- pattern_table_offset  input  3  fine row (0-7) within the tile
- ppu_ctrl1  input  8  PPU control; bit 4 selects the background pattern table (0 = 0x0000, 1 = 0x1000)
- vram_addr  output  16  VRAM read address
- vram_rd_req  output  1  VRAM read request
- vram_rd_ack  input  1  read complete; vram_rd_data valid this cycle
- vram_rd_data  input  8  VRAM read data
- tile_valid  output  1  tile output registers hold a valid tile
- tile_ready  input  1  consumer takes the tile
- tile_pattern_lo  output  8  pattern plane 0 byte
- tile_pattern_hi  output  8  pattern plane 1 byte
- tile_palette  output  2  attribute palette select

Function
REQ-002 SHALL implement states IDLE, FETCH_NT, FETCH_AT, FETCH_PLO, FETCH_PHI and WAIT_OUT.
REQ-003 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready on a rising edge.
REQ-004 On acceptance, SHALL latch nametable_ptr, pattern_table_offset and ppu_ctrl1[4] and enter FETCH_NT; input changes after acceptance SHALL have no effect.
REQ-005 SHALL assert vram_rd_req combinationally in the FETCH_* states only and hold it, with a stable vram_addr, until vram_rd_ack.
REQ-006 SHALL accept vram_rd_ack in the same cycle as vram_rd_req (zero wait); arbitrary wait cycles SHALL be tolerated.
REQ-007 SHALL ignore vram_rd_ack while vram_rd_req = 0.
REQ-008 The FETCH_NT address SHALL be the latched nametable_ptr; on ack, SHALL latch the tile index (NT) and go to FETCH_AT.
REQ-009 The FETCH_AT address SHALL be 0x23C0 | (ptr & 0x0C00) | ((ptr >> 4) & 0x38) | ((ptr >> 2) & 0x07); on ack, SHALL latch the attribute byte and go to FETCH_PLO.
REQ-010 The palette SHALL be attribute bits [s+1:s], where s = {ptr[6], ptr[1], 1'b0}; ptr[6] is coarse_y bit 1 and ptr[1] is coarse_x bit 1.
REQ-011 The FETCH_PLO address SHALL be {3'b0, ctrl4, NT, 1'b0, fine_y}; on ack, SHALL latch the plane-0 byte and go to FETCH_PHI.
REQ-012 The FETCH_PHI address SHALL be {3'b0, ctrl4, NT, 1'b1, fine_y}, i.e. the plane-0 address + 8.
REQ-013 On the FETCH_PHI ack, if the output is free (tile_valid == 0 or tile_ready == 1) the tile registers SHALL load that edge and the FSM SHALL return to IDLE; otherwise the FSM SHALL enter WAIT_OUT with the byte held.
REQ-014 WAIT_OUT SHALL load the output and go to IDLE on the first edge with tile_ready == 1.
REQ-015 tile_valid SHALL set on an output load and clear when tile_ready == 1 with no simultaneous load; a simultaneous load and consume SHALL keep tile_valid at 1 with the new data.
REQ-016 The tile outputs SHALL be stable while tile_valid == 1 and tile_ready == 0.
REQ-017 Zero-wait latency SHALL be: accept at edge 0, NT/AT/PLO/PHI requests in cycles 1-4, tile_valid = 1 after edge 4.
REQ-018 Address math SHALL be unsigned 16-bit with no range check; a ptr in the attribute area SHALL still be fetched per REQ-008/009.

Reset
REQ-019 When rst = 1 at a rising edge: state = IDLE, vram_rd_req = 0, tile_valid = 0, tile_pattern_lo = tile_pattern_hi = 0x00, tile_palette = 0, internal latches = 0.
REQ-020 Reset mid-fetch SHALL abandon the fetch; an ack arriving after reset SHALL be ignored.
REQ-021 rst SHALL override req_valid and tile_ready in the same cycle.

Verification
REQ-022 Zero-wait fetch:
- stimulus: ptr = 0x2863, offset = 5, ctrl1 = 0x10; data NT = 0x3A, AT = 0xE4, lo = 0x81, hi = 0x7E
- required: addresses 0x2863, 0x2BC0, 0x13A5, 0x13AD in cycles 1-4; tile_valid after edge 4; lo = 0x81, hi = 0x7E, palette = 3
REQ-023 Wait states:
- stimulus: ptr = 0x2421, offset = 0, ctrl1 = 0x00; ack delayed 3 cycles per read
- required: each address held 4 cycles with req high; addresses 0x2421, 0x27C0, {NT,0000}, {NT,1000}; palette = AT[1:0]
REQ-024 Output backpressure:
- stimulus: tile_ready = 0 through two requests
- required: second fetch parks in WAIT_OUT, req_ready = 0, first tile stable; one tile_ready pulse shows the second tile the next cycle
REQ-025 Reset mid-fetch:
- stimulus: rst during FETCH_AT, then a stray ack
- required: IDLE, vram_rd_req = 0, tile_valid = 0, outputs 0; stray ack has no effect; next request fetches normally
REQ-026 Spurious inputs:
- stimulus: vram_rd_ack pulses in IDLE; req_valid while busy
- required: no state change; the request is not accepted until req_ready = 1
